// File: rtl/compare_pipe.sv
// rtl/compare_pipe.sv - pipelined magnitude comparator with max select
// Pair-wise flag tree with a single global advance enable; operands ride alongside the flags.
module compare_pipe #(
  parameter int WIDTH = 16,
  parameter int LAT   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             more,
  output logic             less,
  output logic             equal,
  output logic [WIDTH-1:0] max
);

  localparam int NP = WIDTH / 2;
  // All stages' flags packed in one vector: stage s starts at WIDTH - 2*(NP>>s).
  localparam int NF = WIDTH - 1;

  logic                        adv;
  logic [LAT-1:0]              v_q, v_d;
  logic [LAT-1:0][WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [NF-1:0]               m_q, m_d, l_q, l_d;
  logic [NF-1:0]               m_nx, l_nx;
  logic [WIDTH-1:0]            ax, bx;

  assign adv      = !v_q[LAT-1] | out_ready;
  assign in_ready = adv;

  // Flipping the sign bit maps two's complement order onto unsigned order.
  assign ax = {a[WIDTH-1] ^ sgn, a[WIDTH-2:0]};
  assign bx = {b[WIDTH-1] ^ sgn, b[WIDTH-2:0]};

  for (genvar i = 0; i < NP; i++) begin : g_s0
    assign m_nx[i] = (ax[2*i+1] & !bx[2*i+1]) |
                     ((ax[2*i+1] ~^ bx[2*i+1]) & ax[2*i] & !bx[2*i]);
    assign l_nx[i] = (bx[2*i+1] & !ax[2*i+1]) |
                     ((ax[2*i+1] ~^ bx[2*i+1]) & bx[2*i] & !ax[2*i]);
  end

  for (genvar s = 1; s < LAT; s++) begin : g_st
    for (genvar i = 0; i < (NP >> s); i++) begin : g_pr
      localparam int LO = WIDTH - 2 * (NP >> (s - 1)) + 2 * i;
      localparam int O  = WIDTH - 2 * (NP >> s) + i;
      assign m_nx[O] = m_q[LO+1] | (!m_q[LO+1] & !l_q[LO+1] & m_q[LO]);
      assign l_nx[O] = l_q[LO+1] | (!m_q[LO+1] & !l_q[LO+1] & l_q[LO]);
    end
  end

  always_comb begin
    v_d = v_q;
    a_d = a_q;
    b_d = b_q;
    m_d = m_q;
    l_d = l_q;
    if (adv) begin
      v_d = {v_q[LAT-2:0], in_valid};
      a_d = {a_q[LAT-2:0], a};
      b_d = {b_q[LAT-2:0], b};
      m_d = m_nx;
      l_d = l_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      a_q <= '0;
      b_q <= '0;
      m_q <= '0;
      l_q <= '0;
    end else begin
      v_q <= v_d;
      a_q <= a_d;
      b_q <= b_d;
      m_q <= m_d;
      l_q <= l_d;
    end
  end

  assign out_valid = v_q[LAT-1];
  assign more      = out_valid & m_q[NF-1];
  assign less      = out_valid & l_q[NF-1];
  assign equal     = out_valid & !m_q[NF-1] & !l_q[NF-1];
  assign max       = l_q[NF-1] ? b_q[LAT-1] : a_q[LAT-1];

endmodule
